// File: rtl/data_table_search_dispatcher.sv
// Dispatches hash-table tasks to ENGINES_CNT search engines, arbitrates the shared RAM read port
// and merges engine results. Optional macro IN_ORDER_RES_EN returns results in acceptance order.
module data_table_search_dispatcher #(
  parameter int unsigned ENGINES_CNT = 3,
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned A_WIDTH     = 10,
  parameter int unsigned TASK_WIDTH  = 64,
  parameter int unsigned RES_WIDTH   = 32,
  parameter int unsigned ORDER_DEPTH = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [TASK_WIDTH-1:0]            task_i,
  input  logic                             task_valid_i,
  output logic                             task_ready_o,
  output logic [TASK_WIDTH-1:0]            eng_task_o,
  output logic [ENGINES_CNT-1:0]           eng_task_run_o,
  input  logic [ENGINES_CNT-1:0]           eng_busy_i,
  input  logic [ENGINES_CNT*A_WIDTH-1:0]   eng_rd_addr_i,
  input  logic [ENGINES_CNT-1:0]           eng_rd_en_i,
  output logic [ENGINES_CNT-1:0]           rd_avail_o,
  output logic [ENGINES_CNT-1:0]           rd_data_val_o,
  output logic [A_WIDTH-1:0]               rd_addr_o,
  output logic                             rd_en_o,
  output logic                             rd_err_o,
  input  logic [ENGINES_CNT*RES_WIDTH-1:0] eng_res_i,
  input  logic [ENGINES_CNT-1:0]           eng_res_valid_i,
  output logic [ENGINES_CNT-1:0]           eng_res_ready_o,
  output logic [RES_WIDTH-1:0]             res_o,
  output logic                             res_valid_o,
  input  logic                             res_ready_i
);

  localparam int unsigned IDX_W = (ENGINES_CNT > 1) ? $clog2(ENGINES_CNT) : 1;

  if (RAM_LATENCY < 1) begin : g_lat_chk
    $error("RAM_LATENCY must be at least 1");
  end
  if (ORDER_DEPTH < ENGINES_CNT) begin : g_depth_chk
    $error("ORDER_DEPTH must be at least ENGINES_CNT");
  end

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= ENGINES_CNT) s = s - ENGINES_CNT;
    return s[IDX_W-1:0];
  endfunction

  // ---------------------------------------------------------------- dispatch
  logic [ENGINES_CNT-1:0] free;
  logic [IDX_W-1:0]       disp_ptr_q;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_found;
  logic                   fifo_full;
  logic                   accept;

  assign free       = ~eng_busy_i;
  assign eng_task_o = task_i;

  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int unsigned k = 0; k < ENGINES_CNT; k++) begin
      if (!grant_found && free[wrap_add(disp_ptr_q, k)]) begin
        grant_idx   = wrap_add(disp_ptr_q, k);
        grant_found = 1'b1;
      end
    end
  end

  assign task_ready_o = (|free) && !fifo_full;
  assign accept       = task_valid_i && task_ready_o;

  always_comb begin
    eng_task_run_o = '0;
    if (accept) eng_task_run_o[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      disp_ptr_q <= '0;
    end else if (accept) begin
      disp_ptr_q <= wrap_add(grant_idx, 1);
    end
  end

  // ---------------------------------------------------------------- RAM read token
  logic [ENGINES_CNT-1:0] rd_avail_q;
  logic [ENGINES_CNT-1:0] rd_avail_d;
  logic [ENGINES_CNT-1:0] rd_hit;
  logic                   rd_err_q;
  logic [ENGINES_CNT-1:0] dly_q [RAM_LATENCY];

  if (ENGINES_CNT == 1) begin : g_tok_single
    assign rd_avail_d = 1'b1;
  end else begin : g_tok_rot
    assign rd_avail_d = {rd_avail_q[ENGINES_CNT-2:0], rd_avail_q[ENGINES_CNT-1]};
  end

  // Requests from engines not holding the token are dropped, never forwarded.
  assign rd_hit  = eng_rd_en_i & rd_avail_q;
  assign rd_en_o = |rd_hit;

  always_comb begin
    rd_addr_o = '0;
    for (int unsigned i = 0; i < ENGINES_CNT; i++) begin
      if (rd_avail_q[i]) rd_addr_o = eng_rd_addr_i[i*A_WIDTH +: A_WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_avail_q <= ENGINES_CNT'(1);
      rd_err_q   <= 1'b0;
      for (int unsigned i = 0; i < RAM_LATENCY; i++) dly_q[i] <= '0;
    end else begin
      rd_avail_q <= rd_avail_d;
      rd_err_q   <= rd_err_q | (|(eng_rd_en_i & ~rd_avail_q));
      dly_q[0]   <= rd_hit;
      for (int unsigned i = 1; i < RAM_LATENCY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign rd_avail_o    = rd_avail_q;
  assign rd_err_o      = rd_err_q;
  assign rd_data_val_o = dly_q[RAM_LATENCY-1];

  // ---------------------------------------------------------------- result merge
  logic [IDX_W-1:0] sel;
  logic             res_hs;

  assign res_hs = res_valid_o && res_ready_i;

`ifdef IN_ORDER_RES_EN
  localparam int unsigned OPTR_W = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(ORDER_DEPTH + 1);

  logic [IDX_W-1:0]  ord_q [ORDER_DEPTH];
  logic [OPTR_W-1:0] ord_wr_q;
  logic [OPTR_W-1:0] ord_rd_q;
  logic [CNT_W-1:0]  ord_cnt_q;
  logic              fifo_empty;

  function automatic logic [OPTR_W-1:0] ord_inc(input logic [OPTR_W-1:0] p);
    return (p == OPTR_W'(ORDER_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Fullness is judged before any same-cycle pop, so a full FIFO always blocks accept.
  assign fifo_full  = (ord_cnt_q == CNT_W'(ORDER_DEPTH));
  assign fifo_empty = (ord_cnt_q == '0);
  assign sel        = ord_q[ord_rd_q];
  assign res_valid_o = !fifo_empty && eng_res_valid_i[sel];

  always_ff @(posedge clk_i) begin
    if (accept) ord_q[ord_wr_q] <= grant_idx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ord_wr_q  <= '0;
      ord_rd_q  <= '0;
      ord_cnt_q <= '0;
    end else begin
      if (accept) ord_wr_q <= ord_inc(ord_wr_q);
      if (res_hs) ord_rd_q <= ord_inc(ord_rd_q);
      if (accept && !res_hs) ord_cnt_q <= ord_cnt_q + 1'b1;
      else if (!accept && res_hs) ord_cnt_q <= ord_cnt_q - 1'b1;
    end
  end
`else
  logic [IDX_W-1:0] res_ptr_q;
  logic             res_found;

  assign fifo_full = 1'b0;

  always_comb begin
    sel       = '0;
    res_found = 1'b0;
    for (int unsigned k = 0; k < ENGINES_CNT; k++) begin
      if (!res_found && eng_res_valid_i[wrap_add(res_ptr_q, k)]) begin
        sel       = wrap_add(res_ptr_q, k);
        res_found = 1'b1;
      end
    end
  end

  assign res_valid_o = |eng_res_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_ptr_q <= '0;
    end else if (res_hs) begin
      res_ptr_q <= wrap_add(sel, 1);
    end
  end
`endif

  always_comb begin
    res_o = '0;
    for (int unsigned i = 0; i < ENGINES_CNT; i++) begin
      if (sel == IDX_W'(i)) res_o = eng_res_i[i*RES_WIDTH +: RES_WIDTH];
    end
    eng_res_ready_o = '0;
    if (res_valid_o) eng_res_ready_o[sel] = res_ready_i;
  end

endmodule
